// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by the fetch/decode queue and later stages.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched word; the ID/EX payload reuses this layout.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_core.sv
// Generic storage for the fetch queue: entry array, wrapping pointers and occupancy.
module sync_fifo_core
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  fetch_entry_t       wr_data,
    output fetch_entry_t       rd_data,
    output logic [PTR_W:0]     count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller forgets to gate.
    assign do_push = push && !clear && (count != FULL_COUNT);
    assign do_pop  = pop && !clear && (count != '0);

    // Payload storage is deliberately left unreset; occupancy decides validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

    count_in_range: assert property (@(posedge clock) disable iff (reset) count <= FULL_COUNT);

endmodule

// File: rtl/fetch_decode_queue.sv
// Decoupling queue between fetch and decode, with redirect flush and a saturating drop counter.
module fetch_decode_queue
    import pipeline_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              PTR_W     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_instruction,
    output logic              in_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc_plus4,
    output logic [XLEN-1:0]   out_instruction,
    input  logic              out_ready,
    output logic [PTR_W:0]    count,
    output logic [7:0]        flush_drops
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;
    logic         push;
    logic         pop;
    logic [8:0]   drop_sum;

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign wr_entry.pc       = in_pc;
    assign wr_entry.pc_plus4 = in_pc_plus4;
    assign wr_entry.instr    = in_instruction;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (count)
    );

    // Empty queue presents a harmless NOP so decode never sees stale storage.
    always_comb begin
        out_pc          = '0;
        out_pc_plus4    = '0;
        out_instruction = NOP_INSTR;
        if (out_valid) begin
            out_pc          = head_entry.pc;
            out_pc_plus4    = head_entry.pc_plus4;
            out_instruction = head_entry.instr;
        end
    end

    assign drop_sum = {1'b0, flush_drops} + 9'(count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_drops <= '0;
        end else if (flush) begin
            flush_drops <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue with hand-computed expectations.
module tb_fetch_decode_queue;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [2:0]  count;
    logic [7:0]  flush_drops;

    int assertCount = 0;
    int failCount   = 0;

    fetch_decode_queue dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_pc_plus4     (in_pc_plus4),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .out_instruction (out_instruction),
        .out_ready       (out_ready),
        .count           (count),
        .flush_drops     (flush_drops)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic ordy, input logic fl);
        in_valid       = v;
        in_pc          = pc;
        in_pc_plus4    = pc + 32'd4;
        in_instruction = instr;
        out_ready      = ordy;
        flush          = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_pc_plus4 = '0;
        in_instruction = '0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_nop", out_instruction, 32'h0000_0013);
        checkOutput("rst_drops", 32'(flush_drops), 32'd0);
        reset = 1'b0;

        $display("[TB] Fill three words without popping");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hAAAA_0001 + 32'(i), 1'b0, 1'b0);
            checkOutput("t1_count", 32'(count), 32'(i + 1));
            checkOutput("t1_head_pc", out_pc, 32'h100);
            checkOutput("t1_head_instr", out_instruction, 32'hAAAA_0001);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("t1_hold_count", 32'(count), 32'd3);
        checkOutput("t1_hold_pc4", out_pc_plus4, 32'h104);

        $display("[TB] Fill to full, overflow attempt, pop while full");
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hBBBB_0000 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("t2_full_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_full_count", 32'(count), 32'd4);
        applyStimulus(1'b1, 32'h310, 32'hBBBB_0004, 1'b0, 1'b0);
        checkOutput("t2_ovf_count", 32'(count), 32'd4);
        checkOutput("t2_ovf_head", out_pc, 32'h300);
        applyStimulus(1'b1, 32'h314, 32'hBBBB_0005, 1'b1, 1'b0);
        checkOutput("t2_pop_pc", out_pc, 32'h304);
        checkOutput("t2_pop_count", 32'(count), 32'd3);
        checkOutput("t2_pop_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_drain_pc1", out_pc, 32'h308);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_drain_pc2", out_pc, 32'h30C);
        checkOutput("t2_drain_instr2", out_instruction, 32'hBBBB_0003);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_empty_count", 32'(count), 32'd0);
        checkOutput("t2_empty_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("t2_underflow_count", 32'(count), 32'd0);

        $display("[TB] Streaming push and pop across pointer wrap");
        pulseReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'(4 * k), 32'hC000_0000 | 32'(4 * k), 1'b1, 1'b0);
            checkOutput("t3_count", 32'(count), 32'd1);
            checkOutput("t3_pc", out_pc, 32'(4 * k));
            checkOutput("t3_instr", out_instruction, 32'hC000_0000 | 32'(4 * k));
        end

        $display("[TB] Flush with simultaneous push and pop");
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'hEEEE_0000 + 32'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'h200, 32'hFFFF_0200, 1'b1, 1'b1);
        checkOutput("t4_count", 32'(count), 32'd0);
        checkOutput("t4_valid", 32'(out_valid), 32'd0);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        checkOutput("t4_nop", out_instruction, 32'h0000_0013);
        checkOutput("t4_pc_zero", out_pc, 32'h0);
        checkOutput("t4_drops", 32'(flush_drops), 32'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("t4_no_200", 32'(count), 32'd0);

        $display("[TB] Repeated full flushes saturate the drop counter");
        for (int i = 1; i <= 90; i++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus(1'b1, 32'h500 + 32'(4 * j), 32'h1234_0000 + 32'(j), 1'b0, 1'b0);
            end
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            checkOutput("t5_drops", 32'(flush_drops), (3 + 4 * i > 255) ? 32'd255 : 32'(3 + 4 * i));
        end

        $display("[TB] Asynchronous reset mid-cycle");
        applyStimulus(1'b1, 32'h600, 32'h6666_0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h604, 32'h6666_0001, 1'b0, 1'b0);
        checkOutput("t6_pre_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_async_count", 32'(count), 32'd0);
        checkOutput("t6_async_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_async_drops", 32'(flush_drops), 32'd0);
        checkOutput("t6_async_nop", out_instruction, 32'h0000_0013);
        #2;
        reset = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'hDDDD_0000, 1'b0, 1'b0);
        checkOutput("t6_push_valid", 32'(out_valid), 32'd1);
        checkOutput("t6_push_instr", out_instruction, 32'hDDDD_0000);
        checkOutput("t6_push_pc4", out_pc_plus4, 32'h4);
        checkOutput("t6_push_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
